// File: rtl/display_port_bridge.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : display_port_bridge                                          |
// | Brief   : kcpsm3 port bus to dsp character port, with cursor and clear |
// | Revision: 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module display_port_bridge #(
  parameter int             COLS       = 80,
  parameter int             ROWS       = 30,
  parameter int             COL_W      = 7,
  parameter int             ROW_W      = 5,
  parameter logic [7:0]     PORT_BASE  = 8'h00,
  parameter logic [7:0]     ATTR_RESET = 8'h07
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       port_id,
  input  logic             write_strobe,
  input  logic             read_strobe,
  input  logic [7:0]       out_port,
  output logic [7:0]       in_port,
  output logic [ROW_W-1:0] dsp_row,
  output logic [COL_W-1:0] dsp_col,
  output logic             dsp_en,
  output logic             dsp_wr,
  output logic [15:0]      dsp_wr_data,
  output logic             busy
);

  localparam logic [COL_W-1:0] c_lastCol = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] c_lastRow = ROW_W'(ROWS - 1);
  localparam logic [7:0]       c_colMax  = 8'(COLS - 1);
  localparam logic [7:0]       c_rowMax  = 8'(ROWS - 1);
  localparam logic [7:0]       c_space   = 8'h20;
  localparam logic [2:0]       c_offCol    = 3'd0;
  localparam logic [2:0]       c_offRow    = 3'd1;
  localparam logic [2:0]       c_offAttr   = 3'd2;
  localparam logic [2:0]       c_offChar   = 3'd3;
  localparam logic [2:0]       c_offCmd    = 3'd4;
  localparam logic [2:0]       c_offStatus = 3'd5;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t           r_state,   w_nextState;
  logic [COL_W-1:0] r_curCol,  w_nextCurCol;
  logic [ROW_W-1:0] r_curRow,  w_nextCurRow;
  logic [7:0]       r_attr,    w_nextAttr;
  logic [COL_W-1:0] r_dspCol,  w_nextDspCol;
  logic [ROW_W-1:0] r_dspRow,  w_nextDspRow;
  logic [15:0]      r_dspData, w_nextDspData;
  logic             r_dspEn,   w_nextDspEn;
  logic             r_overrun, w_nextOverrun;

  logic       w_hit;
  logic [2:0] w_off;
  logic       w_wrCol, w_wrRow, w_wrAttr, w_wrChar, w_wrCmd, w_rdStatus;

  function automatic logic [ROW_W-1:0] incRow(input logic [ROW_W-1:0] row);
    return (row == c_lastRow) ? '0 : row + 1'b1;
  endfunction

  assign w_hit      = (port_id[7:3] == PORT_BASE[7:3]);
  assign w_off      = port_id[2:0];
  assign w_wrCol    = write_strobe & w_hit & (w_off == c_offCol);
  assign w_wrRow    = write_strobe & w_hit & (w_off == c_offRow);
  assign w_wrAttr   = write_strobe & w_hit & (w_off == c_offAttr);
  assign w_wrChar   = write_strobe & w_hit & (w_off == c_offChar);
  assign w_wrCmd    = write_strobe & w_hit & (w_off == c_offCmd);
  assign w_rdStatus = read_strobe  & w_hit & (w_off == c_offStatus);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_curCol  <= '0;
      r_curRow  <= '0;
      r_attr    <= ATTR_RESET;
      r_dspCol  <= '0;
      r_dspRow  <= '0;
      r_dspData <= '0;
      r_dspEn   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_curCol  <= w_nextCurCol;
      r_curRow  <= w_nextCurRow;
      r_attr    <= w_nextAttr;
      r_dspCol  <= w_nextDspCol;
      r_dspRow  <= w_nextDspRow;
      r_dspData <= w_nextDspData;
      r_dspEn   <= w_nextDspEn;
      r_overrun <= w_nextOverrun;
    end
  end

  always_comb begin
    w_nextState   = r_state;
    w_nextCurCol  = r_curCol;
    w_nextCurRow  = r_curRow;
    w_nextAttr    = w_wrAttr ? out_port : r_attr;
    w_nextDspCol  = r_dspCol;
    w_nextDspRow  = r_dspRow;
    w_nextDspData = r_dspData;
    w_nextDspEn   = 1'b0;
    // Set dominates the read-to-clear of the sticky overrun flag.
    w_nextOverrun = (r_overrun & ~w_rdStatus) |
                    ((r_state == S_CLEAR) & (w_wrCol | w_wrRow | w_wrChar | w_wrCmd));

    case (r_state)
      S_IDLE: begin
        if (w_wrCmd && out_port[0]) begin
          w_nextState   = S_CLEAR;
          w_nextDspRow  = '0;
          w_nextDspCol  = '0;
          w_nextDspData = {r_attr, c_space};
          w_nextDspEn   = 1'b1;
        end else if (w_wrCmd && out_port[1]) begin
          w_nextCurCol = '0;
          w_nextCurRow = incRow(r_curRow);
        end else if (w_wrChar) begin
          w_nextDspRow  = r_curRow;
          w_nextDspCol  = r_curCol;
          w_nextDspData = {r_attr, out_port};
          w_nextDspEn   = 1'b1;
          if (r_curCol == c_lastCol) begin
            w_nextCurCol = '0;
            w_nextCurRow = incRow(r_curRow);
          end else begin
            w_nextCurCol = r_curCol + 1'b1;
          end
        end else if (w_wrCol) begin
          w_nextCurCol = (out_port > c_colMax) ? c_lastCol : out_port[COL_W-1:0];
        end else if (w_wrRow) begin
          w_nextCurRow = (out_port > c_rowMax) ? c_lastRow : out_port[ROW_W-1:0];
        end
      end

      S_CLEAR: begin
        // The attribute latched into r_dspData at clear start is held throughout.
        w_nextDspEn = 1'b1;
        if (r_dspCol == c_lastCol) begin
          w_nextDspCol = '0;
          if (r_dspRow == c_lastRow) begin
            w_nextState  = S_IDLE;
            w_nextDspEn  = 1'b0;
            w_nextDspRow = '0;
            w_nextCurCol = '0;
            w_nextCurRow = '0;
          end else begin
            w_nextDspRow = r_dspRow + 1'b1;
          end
        end else begin
          w_nextDspCol = r_dspCol + 1'b1;
        end
      end

      default: w_nextState = S_IDLE;
    endcase
  end

  always_comb begin
    in_port = 8'h00;
    if (w_hit) begin
      case (w_off)
        c_offCol:    in_port = 8'(r_curCol);
        c_offRow:    in_port = 8'(r_curRow);
        c_offAttr:   in_port = r_attr;
        c_offStatus: in_port = {6'b0, r_overrun, (r_state == S_CLEAR)};
        default:     in_port = 8'h00;
      endcase
    end
  end

  assign dsp_row     = r_dspRow;
  assign dsp_col     = r_dspCol;
  assign dsp_en      = r_dspEn;
  assign dsp_wr      = r_dspEn;
  assign dsp_wr_data = r_dspData;
  assign busy        = (r_state == S_CLEAR);

endmodule
`default_nettype wire

// File: tb/tb_display_port_bridge.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_display_port_bridge                                       |
// | Brief   : directed self-checking bench for display_port_bridge         |
// | Revision: 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tb_display_port_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  port_id = 8'h00;
  logic        write_strobe = 1'b0;
  logic        read_strobe = 1'b0;
  logic [7:0]  out_port = 8'h00;
  logic [7:0]  in_port;
  logic [4:0]  dsp_row;
  logic [6:0]  dsp_col;
  logic        dsp_en;
  logic        dsp_wr;
  logic [15:0] dsp_wr_data;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int enTotal = 0;

  display_port_bridge dut (
    .clk(clk), .reset(reset), .port_id(port_id), .write_strobe(write_strobe),
    .read_strobe(read_strobe), .out_port(out_port), .in_port(in_port),
    .dsp_row(dsp_row), .dsp_col(dsp_col), .dsp_en(dsp_en), .dsp_wr(dsp_wr),
    .dsp_wr_data(dsp_wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (dsp_en) enTotal <= enTotal + 1;

  task automatic wr(input logic [7:0] addr, input logic [7:0] data);
    @(negedge clk);
    port_id = addr; out_port = data; write_strobe = 1'b1;
    @(negedge clk);
    write_strobe = 1'b0;
  endtask

  task automatic rd(input logic [7:0] addr, output logic [7:0] data);
    @(negedge clk);
    port_id = addr; read_strobe = 1'b1;
    #1 data = in_port;
    @(negedge clk);
    read_strobe = 1'b0;
  endtask

  task automatic test_reset;
    logic [7:0] d;
    repeat (3) @(negedge clk);
    checks++;
    if ({dsp_en, dsp_wr, busy, dsp_row, dsp_col, dsp_wr_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: en=%b wr=%b busy=%b row=%0d col=%0d data=%h, want all zero",
               dsp_en, dsp_wr, busy, dsp_row, dsp_col, dsp_wr_data);
    end
    reset = 1'b1;
    rd(8'h00, d); checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL reset_col: got %h want 00", d); end
    rd(8'h01, d); checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL reset_row: got %h want 00", d); end
    rd(8'h02, d); checks++;
    if (d !== 8'h07) begin errors++; $display("FAIL reset_attr: got %h want 07", d); end
    rd(8'h05, d); checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL reset_status: got %h want 00", d); end
    rd(8'h06, d); checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL unmapped_read: got %h want 00", d); end
    checks++;
    if (enTotal !== 0) begin errors++; $display("FAIL reset_no_write: got %0d writes want 0", enTotal); end
  endtask

  task automatic test_corner_char;
    logic [7:0] d;
    int e0;
    wr(8'h00, 8'd79);
    wr(8'h01, 8'd29);
    e0 = enTotal;
    wr(8'h03, 8'h41);
    checks++;
    if (enTotal !== e0) begin errors++; $display("FAIL char_latency_early: got %0d extra writes want 0", enTotal - e0); end
    checks++;
    if ({dsp_en, dsp_wr, dsp_row, dsp_col, dsp_wr_data} !== {1'b1, 1'b1, 5'd29, 7'd79, 16'h0741}) begin
      errors++;
      $display("FAIL char_corner: en=%b wr=%b row=%0d col=%0d data=%h, want 1 1 29 79 0741",
               dsp_en, dsp_wr, dsp_row, dsp_col, dsp_wr_data);
    end
    @(negedge clk); checks++;
    if (dsp_en !== 1'b0) begin errors++; $display("FAIL char_pulse_width: en=%b want 0", dsp_en); end
    rd(8'h00, d); checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL wrap_col: got %h want 00", d); end
    rd(8'h01, d); checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL wrap_row: got %h want 00", d); end
  endtask

  task automatic test_clamp_advance;
    logic [7:0] d;
    wr(8'h00, 8'd200);
    rd(8'h00, d); checks++;
    if (d !== 8'd79) begin errors++; $display("FAIL col_clamp: got %0d want 79", d); end
    wr(8'h01, 8'd255);
    rd(8'h01, d); checks++;
    if (d !== 8'd29) begin errors++; $display("FAIL row_clamp: got %0d want 29", d); end
    wr(8'h01, 8'd5);
    wr(8'h03, 8'h42); checks++;
    if ({dsp_en, dsp_row, dsp_col, dsp_wr_data} !== {1'b1, 5'd5, 7'd79, 16'h0742}) begin
      errors++;
      $display("FAIL char_first: en=%b row=%0d col=%0d data=%h, want 1 5 79 0742", dsp_en, dsp_row, dsp_col, dsp_wr_data);
    end
    wr(8'h03, 8'h43); checks++;
    if ({dsp_en, dsp_row, dsp_col, dsp_wr_data} !== {1'b1, 5'd6, 7'd0, 16'h0743}) begin
      errors++;
      $display("FAIL char_rowwrap: en=%b row=%0d col=%0d data=%h, want 1 6 0 0743", dsp_en, dsp_row, dsp_col, dsp_wr_data);
    end
  endtask

  task automatic test_clear;
    logic [7:0] d;
    int bad;
    bad = 0;
    wr(8'h02, 8'h1E);
    wr(8'h04, 8'h01);
    for (int i = 0; i < 2400; i++) begin
      checks++;
      if ({busy, dsp_en, dsp_wr, dsp_row, dsp_col, dsp_wr_data} !==
          {1'b1, 1'b1, 1'b1, 5'(i / 80), 7'(i % 80), 16'h1E20}) begin
        errors++; bad++;
        if (bad < 5)
          $display("FAIL clear_cell %0d: busy=%b en=%b wr=%b row=%0d col=%0d data=%h, want 1 1 1 %0d %0d 1e20",
                   i, busy, dsp_en, dsp_wr, dsp_row, dsp_col, dsp_wr_data, i / 80, i % 80);
      end
      if (i == 3) begin port_id = 8'h02; out_port = 8'h55; write_strobe = 1'b1; end
      if (i == 4) write_strobe = 1'b0;
      @(negedge clk);
    end
    checks++;
    if ({busy, dsp_en} !== 2'b00) begin errors++; $display("FAIL clear_end: busy=%b en=%b want 0 0", busy, dsp_en); end
    rd(8'h00, d); checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL clear_cursor_col: got %h want 00", d); end
    rd(8'h01, d); checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL clear_cursor_row: got %h want 00", d); end
    rd(8'h02, d); checks++;
    if (d !== 8'h55) begin errors++; $display("FAIL attr_during_clear: got %h want 55", d); end
  endtask

  task automatic test_overrun;
    logic [7:0] d;
    int e0;
    int waited;
    e0 = enTotal;
    wr(8'h04, 8'h01);
    wr(8'h03, 8'h58);
    rd(8'h05, d); checks++;
    if (d !== 8'h03) begin errors++; $display("FAIL status_busy_overrun: got %h want 03", d); end
    wr(8'h00, 8'd5);
    waited = 0;
    while (busy === 1'b1 && waited < 3000) begin @(negedge clk); waited++; end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL clear_timeout: busy=%b after %0d cycles want 0", busy, waited); end
    checks++;
    if (enTotal - e0 !== 2400) begin errors++; $display("FAIL clear_write_count: got %0d want 2400", enTotal - e0); end
    rd(8'h05, d); checks++;
    if (d !== 8'h02) begin errors++; $display("FAIL status_sticky: got %h want 02", d); end
    rd(8'h05, d); checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL status_cleared: got %h want 00", d); end
    rd(8'h00, d); checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL col_dropped: got %h want 00", d); end
  endtask

  task automatic test_reset_mid_clear;
    logic [7:0] d;
    int e0;
    wr(8'h04, 8'h01);
    repeat (100) @(negedge clk);
    reset = 1'b0;
    #1 checks++;
    if ({dsp_en, dsp_wr, busy} !== 3'b000) begin
      errors++; $display("FAIL reset_abort: en=%b wr=%b busy=%b want 0 0 0", dsp_en, dsp_wr, busy);
    end
    e0 = enTotal;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (enTotal !== e0) begin errors++; $display("FAIL reset_no_resume: got %0d writes want 0", enTotal - e0); end
    wr(8'h00, 8'd10);
    wr(8'h01, 8'd3);
    wr(8'h04, 8'h02);
    @(negedge clk);
    rd(8'h00, d); checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL newline_col: got %0d want 0", d); end
    rd(8'h01, d); checks++;
    if (d !== 8'd4) begin errors++; $display("FAIL newline_row: got %0d want 4", d); end
    checks++;
    if (enTotal !== e0) begin errors++; $display("FAIL newline_no_write: got %0d writes want 0", enTotal - e0); end
    rd(8'h02, d); checks++;
    if (d !== 8'h07) begin errors++; $display("FAIL reset_attr_again: got %h want 07", d); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] d;
    wr(8'h00, 8'd78);
    wr(8'h01, 8'd2);
    @(negedge clk);
    port_id = 8'h03; out_port = 8'h61; write_strobe = 1'b1;
    @(negedge clk);
    checks++;
    if ({dsp_en, dsp_row, dsp_col, dsp_wr_data} !== {1'b1, 5'd2, 7'd78, 16'h0761}) begin
      errors++; $display("FAIL b2b_first: en=%b row=%0d col=%0d data=%h, want 1 2 78 0761", dsp_en, dsp_row, dsp_col, dsp_wr_data);
    end
    out_port = 8'h62;
    @(negedge clk);
    write_strobe = 1'b0;
    checks++;
    if ({dsp_en, dsp_row, dsp_col, dsp_wr_data} !== {1'b1, 5'd2, 7'd79, 16'h0762}) begin
      errors++; $display("FAIL b2b_second: en=%b row=%0d col=%0d data=%h, want 1 2 79 0762", dsp_en, dsp_row, dsp_col, dsp_wr_data);
    end
    rd(8'h01, d); checks++;
    if (d !== 8'd3) begin errors++; $display("FAIL b2b_row: got %0d want 3", d); end
    wr(8'h01, 8'd29);
    wr(8'h04, 8'h02);
    rd(8'h01, d); checks++;
    if (d !== 8'd0) begin errors++; $display("FAIL newline_wrap: got %0d want 0", d); end
  endtask

  initial begin
    test_reset;
    test_corner_char;
    test_clamp_advance;
    test_clear;
    test_overrun;
    test_reset_mid_clear;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
